// File: rtl/chan_mux_rr_if.sv
// chan_mux_rr_if -- channel-side and output-side handshake bundle for chan_mux_rr.
//   mode, s       : arbitration mode (0 select, 1 round-robin) and channel select
//   in_valid/data : per-channel offers, channel k data at in_data[k*W +: W]
//   in_ready      : per-channel accept strobe (one-hot or zero)
//   y_valid/y/y_ch: registered output word and its source channel
//   y_ready       : downstream accepts y
// slave = the mux, master = whoever drives channels and consumes y.
interface chan_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic              mode;
  logic [SW-1:0]     s;
  logic [N-1:0]      in_valid;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_ready;
  logic              y_valid;
  logic [W-1:0]      y;
  logic [SW-1:0]     y_ch;
  logic              y_ready;

  modport master (
    output mode, s, in_valid, in_data, y_ready,
    input  in_ready, y_valid, y, y_ch
  );

  modport slave (
    input  mode, s, in_valid, in_data, y_ready,
    output in_ready, y_valid, y, y_ch
  );
endinterface

// File: rtl/chan_mux_rr.sv
// chan_mux_rr -- N-channel to 1 registered mux with select-driven or
// round-robin arbitration and a single-entry output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chan_mux_rr_if slave (see interface header for signals)
// A word is accepted from the granted channel whenever the output register
// is empty or being drained this cycle, so throughput is one word per clock.

// Per-channel slice: select-mode request decode and accept strobe.
module chan_mux_rr_lane #(
  parameter int SW = 2,
  parameter int K  = 0
) (
  input  logic          valid,
  input  logic [SW-1:0] s,
  input  logic          gnt,
  input  logic          ld,
  output logic          sel_req,
  output logic          ready
);
  // s values with no matching lane (s >= N) simply never hit.
  assign sel_req = valid & (s == SW'(K));
  assign ready   = gnt & ld;
endmodule

module chan_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_rr_if.slave  bus
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic          gv;
  logic          ld;
  logic [N-1:0]  sel_req;
  logic [N-1:0]  gnt_oh;
  logic [N-1:0]  rdy;
  logic [W-1:0]  din;

  logic          y_valid_q;
  logic [W-1:0]  y_q;
  logic [SW-1:0] y_ch_q;

  // Load when empty or draining; y_ready reaches in_ready only, never y.
  assign ld = ~y_valid_q | bus.y_ready;

  // Grant: decoded select in mode 0, first valid from ptr upward in mode 1.
  // The rotating search walks downward so the lowest offset wins last.
  always_comb begin
    int idx;
    idx = 0;
    g   = '0;
    gv  = 1'b0;
    if (!bus.mode) begin
      for (int k = 0; k < N; k++) begin
        if (sel_req[k]) begin
          g  = SW'(k);
          gv = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (bus.in_valid[idx]) begin
          g  = SW'(idx);
          gv = 1'b1;
        end
      end
    end
  end

  // One-hot grant, suppressed during reset so in_ready stays low.
  always_comb begin
    gnt_oh = '0;
    din    = '0;
    for (int k = 0; k < N; k++) begin
      gnt_oh[k] = gv & rst_n & (g == SW'(k));
      if (g == SW'(k)) din = bus.in_data[k*W +: W];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    chan_mux_rr_lane #(.SW(SW), .K(k)) u_lane (
      .valid   (bus.in_valid[k]),
      .s       (bus.s),
      .gnt     (gnt_oh[k]),
      .ld      (ld),
      .sel_req (sel_req[k]),
      .ready   (rdy[k])
    );
  end

  assign bus.in_ready = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_ch_q    <= '0;
      ptr       <= '0;
    end else if (ld && gv) begin
      y_valid_q <= 1'b1;
      y_q       <= din;
      y_ch_q    <= g;
      // Pointer advances past the winner on round-robin transfers only.
      if (bus.mode) ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.y_valid = y_valid_q;
  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, 1..64.
REQ-003 SHALL have derived localparam SW = clog2(N): channel-index width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 1: 0 = select-driven, 1 = round-robin.
REQ-007 SHALL have port s, input, SW: channel select, used in mode 0 only.
REQ-008 SHALL have port in_valid, input, N: per-channel valid.
REQ-009 SHALL have port in_data, input, N*W: channel k at bits [k*W +: W].
REQ-010 SHALL have port in_ready, output, N: per-channel accept strobe.
REQ-011 SHALL have port y_valid, output, 1: output register holds a word.
REQ-012 SHALL have port y, output, W: registered output data.
REQ-013 SHALL have port y_ch, output, SW: source channel of y.
REQ-014 SHALL have port y_ready, input, 1: downstream accepts y.

Function
REQ-015 SHALL hold one output register (y, y_ch, y_valid).
- load enable ld = ~y_valid | y_ready.
REQ-016 SHALL compute grant channel g combinationally each cycle.
- mode 0: g = s if s < N and in_valid[s]; else no grant.
- mode 1: g = first k with in_valid[k], searching ptr, ptr+1, ... modulo N; no grant if in_valid = 0.
REQ-017 SHALL drive in_ready[g] = ld when a grant exists; all other in_ready bits 0.
- in_ready SHALL be one-hot or zero, never multi-bit.
REQ-018 SHALL transfer on ld & grant: next cycle y = in_data[g], y_ch = g, y_valid = 1.
- latency: input accept to y_valid = 1 clock.
REQ-019 SHALL clear y_valid on y_valid & y_ready with no new grant in the same cycle.
REQ-020 SHALL hold y, y_ch, y_valid stable while y_valid & ~y_ready.
REQ-021 SHALL support back-to-back throughput: drain and load in the same cycle give one word per clock.
REQ-022 SHALL update round-robin pointer ptr only on a mode-1 transfer: ptr = g+1, wrapping N-1 -> 0.
- mode-0 transfers SHALL NOT change ptr.
REQ-023 SHALL apply a mode change on the next arbitration with no flush; ptr retained.
REQ-024 SHALL ignore s values >= N (non-power-of-2 N): no grant, no transfer.
REQ-025 SHALL keep y and y_ch at their last values when y_valid = 0; no X propagation.
REQ-026 SHALL treat in_data of non-granted channels as don't-care.
REQ-027 SHALL contain no combinational path from y_ready to y or y_valid.
- a combinational path from y_ready to in_ready is permitted.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force y_valid = 0, y = 0, y_ch = 0, ptr = 0.
REQ-029 SHALL drive in_ready = 0 during reset.
REQ-030 SHALL discard any word held in the output register when reset is asserted mid-operation.
REQ-031 SHALL accept a transfer on the first rising edge after rst_n deasserts.

Verification (N=4, W=8)
REQ-032 mode 0, s=2, in_valid=0100, ch2 data=0xA5, y_ready=1:
- in_ready=0100 in the same cycle.
- next cycle: y=0xA5, y_ch=2, y_valid=1.
REQ-033 mode 1, in_valid=1111 held, y_ready=1, ptr=0:
- y_ch sequence 0,1,2,3,0 on consecutive clocks.
- y_valid continuously 1 from the first load.
REQ-034 mode 1, in_valid=1010, ptr=0:
- grants ch1 then ch3, then ch1 again.
- ptr values after each transfer: 2, 0, 2.
REQ-035 y_valid=1 with y=0x3C, y_ready=0 for 5 clocks while inputs change:
- y stays 0x3C, y_ch unchanged.
- in_ready=0000 throughout.
REQ-036 rst_n pulsed low mid-stream with y_valid=1:
- y_valid=0, y=0, y_ch=0 immediately, with no clock edge required.
- after release, mode 1 restarts at ch0.
REQ-037 N=3, mode 0, s=3, in_valid=111:
- no grant, in_ready=000.
- y_valid remains 0.
